// File: rtl/axil_pkg.sv
// AXI4-Lite response codes and responder FSM states.
// Shared by the RAM responder and the MMU initiator.
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } w_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_RESP
   } r_state_t;

endpackage

// File: rtl/axil_ram_array.sv
// Simple dual-port word RAM with byte enables.
// Registered read port, read-first on same-address collision.
module axil_ram_array #(
   parameter int DEPTH_WORDS = 16384,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Byte-lane write and registered read; NBA ordering gives old data.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we && be[i]) begin
            mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/axil_ram_responder.sv
// AXI4-Lite responder over block RAM.
// Independent read/write channels, DECERR beyond DEPTH_WORDS.
module axil_ram_responder
   import axil_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DEPTH_WORDS = 16384
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [31:0]       s_axi_wdata,
   input  logic [3:0]        s_axi_wstrb,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   output logic [1:0]        s_axi_bresp,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   input  logic [ADDR_W-1:0] s_axi_araddr,
   input  logic              s_axi_arvalid,
   output logic              s_axi_arready,
   output logic [31:0]       s_axi_rdata,
   output logic [1:0]        s_axi_rresp,
   output logic              s_axi_rvalid,
   input  logic              s_axi_rready
);

   localparam int RAW = $clog2(DEPTH_WORDS);
   localparam int IW  = ADDR_W - 2;
   localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH_WORDS);

   logic [1:0] unused_addr_lsb;
   assign unused_addr_lsb = s_axi_awaddr[1:0] ^ s_axi_araddr[1:0];

   w_state_t    ws, ws_d;
   logic        aw_held, aw_held_d;
   logic        w_held, w_held_d;
   logic [IW-1:0] aw_idx;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        awready_d, wready_d, bvalid_d;
   logic [1:0]  bresp_d;
   logic        commit;

   r_state_t    rs, rs_d;
   logic        r_ph, r_ph_d;
   logic [IW-1:0] ar_idx;
   logic        arready_d, rvalid_d;
   logic [1:0]  rresp_d;
   logic [31:0] rdata_d;
   logic        ram_re;
   logic [31:0] ram_rdata;

   logic aw_fire, w_fire, ar_fire;
   logic aw_ok, ar_ok;

   assign aw_fire = s_axi_awvalid & s_axi_awready;
   assign w_fire  = s_axi_wvalid & s_axi_wready;
   assign ar_fire = s_axi_arvalid & s_axi_arready;
   assign aw_ok   = {2'b00, aw_idx} < DEPTH_L;
   assign ar_ok   = {2'b00, ar_idx} < DEPTH_L;

   // Write FSM state register.
   always_ff @(posedge clk) begin
      if (!rstn) ws <= W_IDLE;
      else       ws <= ws_d;
   end

   // Write FSM: respond once both AW and W are held.
   always_comb begin
      ws_d = ws;
      unique case (ws)
         W_IDLE:  if (aw_held && w_held) ws_d = W_RESP;
         W_RESP:  if (s_axi_bready) ws_d = W_IDLE;
         default: ws_d = W_IDLE;
      endcase
   end

   // Write-side next values: capture flags, readys, commit, B channel.
   always_comb begin
      aw_held_d = aw_held;
      w_held_d  = w_held;
      awready_d = 1'b0;
      wready_d  = 1'b0;
      bvalid_d  = s_axi_bvalid;
      bresp_d   = s_axi_bresp;
      commit    = 1'b0;
      unique case (ws)
         W_IDLE: begin
            aw_held_d = aw_held | aw_fire;
            w_held_d  = w_held | w_fire;
            awready_d = ~aw_held_d;
            wready_d  = ~w_held_d;
            if (aw_held && w_held) begin
               commit   = 1'b1;
               bvalid_d = 1'b1;
               bresp_d  = aw_ok ? RESP_OKAY : RESP_DECERR;
            end
         end
         W_RESP: begin
            if (s_axi_bready) begin
               bvalid_d  = 1'b0;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Write-side registers and captured AW/W payload.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         aw_held       <= 1'b0;
         w_held        <= 1'b0;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= RESP_OKAY;
         aw_idx        <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
      end else begin
         aw_held       <= aw_held_d;
         w_held        <= w_held_d;
         s_axi_awready <= awready_d;
         s_axi_wready  <= wready_d;
         s_axi_bvalid  <= bvalid_d;
         s_axi_bresp   <= bresp_d;
         if (aw_fire) aw_idx <= s_axi_awaddr[ADDR_W-1:2];
         if (w_fire) begin
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
         end
      end
   end

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (!rstn) rs <= R_IDLE;
      else       rs <= rs_d;
   end

   // Read FSM: R_WAIT spans the RAM read edge and the data-load edge.
   always_comb begin
      rs_d = rs;
      unique case (rs)
         R_IDLE:  if (ar_fire) rs_d = R_WAIT;
         R_WAIT:  if (r_ph) rs_d = R_RESP;
         R_RESP:  if (s_axi_rready) rs_d = R_IDLE;
         default: rs_d = R_IDLE;
      endcase
   end

   // Read-side next values: RAM enable, R channel, arready.
   always_comb begin
      arready_d = 1'b0;
      rvalid_d  = s_axi_rvalid;
      rresp_d   = s_axi_rresp;
      rdata_d   = s_axi_rdata;
      r_ph_d    = 1'b0;
      ram_re    = 1'b0;
      unique case (rs)
         R_IDLE: arready_d = ~ar_fire;
         R_WAIT: begin
            if (!r_ph) begin
               ram_re = 1'b1;
               r_ph_d = 1'b1;
            end else begin
               rvalid_d = 1'b1;
               rresp_d  = ar_ok ? RESP_OKAY : RESP_DECERR;
               rdata_d  = ar_ok ? ram_rdata : 32'd0;
            end
         end
         R_RESP: begin
            if (s_axi_rready) begin
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Read-side registers and captured AR index.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_ph          <= 1'b0;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rresp   <= RESP_OKAY;
         s_axi_rdata   <= '0;
         ar_idx        <= '0;
      end else begin
         r_ph          <= r_ph_d;
         s_axi_arready <= arready_d;
         s_axi_rvalid  <= rvalid_d;
         s_axi_rresp   <= rresp_d;
         s_axi_rdata   <= rdata_d;
         if (ar_fire) ar_idx <= s_axi_araddr[ADDR_W-1:2];
      end
   end

   axil_ram_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (RAW)
   ) u_ram (
      .clk   (clk),
      .we    (commit & aw_ok),
      .be    (wstrb_q),
      .waddr (aw_idx[RAW-1:0]),
      .wdata (wdata_q),
      .re    (ram_re),
      .raddr (ar_idx[RAW-1:0]),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_axil_ram_responder.sv
// Bench for axil_ram_responder: directed plan plus random traffic
// against a transaction-level memory model checked every cycle.
module tb_axil_ram_responder;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [31:0] s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;

   int checks = 0;
   int failures = 0;

   axil_ram_responder #(.ADDR_W(32), .DEPTH_WORDS(16384)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] mem [int];
   logic [3:0]  kn  [int];

   logic        exp_awready, exp_wready, exp_arready;
   logic        exp_bvalid, exp_rvalid;
   logic [1:0]  exp_bresp, exp_rresp;
   logic [31:0] exp_rdata, exp_rmask;
   logic        hs_aw, hs_w, hs_ar, hs_b, hs_r;
   bit          model_ok = 0;
   bit          from_rst = 0;
   bit          aw_have, w_have;
   int          ecount = 0;
   int          wr_cmt = -1, rd_smp = -1, rd_out = -1;
   logic [31:0] m_awaddr, m_wdata, m_araddr, rd_val, rd_msk;
   logic [3:0]  m_wstrb;
   int          idx;

   function automatic bit in_range(input logic [31:0] a);
      return int'(a[31:2]) < 16384;
   endfunction

   always @(negedge clk) begin
      if (model_ok) begin
         chk("awready", s_axi_awready, exp_awready);
         chk("wready", s_axi_wready, exp_wready);
         chk("arready", s_axi_arready, exp_arready);
         chk("bvalid", s_axi_bvalid, exp_bvalid);
         chk("rvalid", s_axi_rvalid, exp_rvalid);
         if (exp_bvalid) chk("bresp", s_axi_bresp, exp_bresp);
         if (exp_rvalid) begin
            chk("rresp", s_axi_rresp, exp_rresp);
            chk("rdata", s_axi_rdata & exp_rmask, exp_rdata & exp_rmask);
         end
      end
      if (!rstn) begin
         exp_awready = 0; exp_wready = 0; exp_arready = 0;
         exp_bvalid = 0; exp_rvalid = 0;
         exp_bresp = 0; exp_rresp = 0;
         exp_rdata = 0; exp_rmask = 0;
         hs_aw = 0; hs_w = 0; hs_ar = 0;
         aw_have = 0; w_have = 0;
         wr_cmt = -1; rd_smp = -1; rd_out = -1;
         model_ok = 1;
         from_rst = 1;
      end else begin
         hs_aw = s_axi_awvalid & exp_awready;
         hs_w  = s_axi_wvalid & exp_wready;
         hs_ar = s_axi_arvalid & exp_arready;
         hs_b  = exp_bvalid & s_axi_bready;
         hs_r  = exp_rvalid & s_axi_rready;
         ecount++;
         if (rd_smp == ecount) begin
            if (in_range(m_araddr)) begin
               idx = int'(m_araddr[31:2]);
               rd_val = mem.exists(idx) ? mem[idx] : 32'd0;
               rd_msk = 32'd0;
               if (kn.exists(idx))
                  for (int i = 0; i < 4; i++)
                     if (kn[idx][i]) rd_msk[8*i +: 8] = 8'hFF;
            end else begin
               rd_val = 32'd0;
               rd_msk = 32'hFFFF_FFFF;
            end
         end
         if (wr_cmt == ecount) begin
            if (in_range(m_awaddr)) begin
               idx = int'(m_awaddr[31:2]);
               if (!mem.exists(idx)) begin
                  mem[idx] = 32'd0;
                  kn[idx] = 4'd0;
               end
               for (int i = 0; i < 4; i++)
                  if (m_wstrb[i]) begin
                     mem[idx][8*i +: 8] = m_wdata[8*i +: 8];
                     kn[idx][i] = 1'b1;
                  end
            end
            exp_bvalid = 1;
            exp_bresp = in_range(m_awaddr) ? 2'b00 : 2'b11;
         end
         if (rd_out == ecount) begin
            exp_rvalid = 1;
            exp_rdata = rd_val;
            exp_rmask = rd_msk;
            exp_rresp = in_range(m_araddr) ? 2'b00 : 2'b11;
         end
         if (hs_aw) begin
            aw_have = 1; m_awaddr = s_axi_awaddr; exp_awready = 0;
         end
         if (hs_w) begin
            w_have = 1; m_wdata = s_axi_wdata; m_wstrb = s_axi_wstrb;
            exp_wready = 0;
         end
         if ((hs_aw || hs_w) && aw_have && w_have) wr_cmt = ecount + 1;
         if (hs_b) begin
            exp_bvalid = 0; aw_have = 0; w_have = 0;
            exp_awready = 1; exp_wready = 1;
         end
         if (hs_ar) begin
            exp_arready = 0; m_araddr = s_axi_araddr;
            rd_smp = ecount + 1; rd_out = ecount + 2;
         end
         if (hs_r) begin
            exp_rvalid = 0; exp_arready = 1;
         end
         if (from_rst) begin
            exp_awready = 1; exp_wready = 1; exp_arready = 1;
            from_rst = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_hs(input string nm, input int which);
      int n = 0;
      bit got;
      do begin
         tick();
         n++;
         got = (which == 0) ? hs_aw : (which == 1) ? hs_w : hs_ar;
      end while (!got && n < 20);
      chk(nm, {31'd0, got}, 32'd1);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int gap, input int bhold,
                     output logic [1:0] resp, output int lat);
      s_axi_bready = (bhold == 0);
      s_axi_awaddr = a;
      s_axi_awvalid = 1;
      wait_hs("aw_timeout", 0);
      s_axi_awvalid = 0;
      repeat (gap) tick();
      s_axi_wdata = d;
      s_axi_wstrb = s;
      s_axi_wvalid = 1;
      wait_hs("w_timeout", 1);
      s_axi_wvalid = 0;
      lat = 0;
      do begin tick(); lat++; end while (!s_axi_bvalid && lat < 20);
      resp = s_axi_bresp;
      for (int i = 0; i < bhold; i++) begin
         chk("bp_awready", s_axi_awready, 0);
         chk("bp_wready", s_axi_wready, 0);
         chk("bp_bvalid", s_axi_bvalid, 1);
         tick();
      end
      s_axi_bready = 1;
      tick();
      s_axi_bready = 0;
   endtask

   task automatic rd(input logic [31:0] a, input int hold,
                     output logic [31:0] d, output logic [1:0] resp,
                     output int lat);
      s_axi_rready = 0;
      s_axi_araddr = a;
      s_axi_arvalid = 1;
      wait_hs("ar_timeout", 2);
      s_axi_arvalid = 0;
      lat = 0;
      do begin tick(); lat++; end while (!s_axi_rvalid && lat < 20);
      d = s_axi_rdata;
      resp = s_axi_rresp;
      for (int i = 0; i < hold; i++) begin
         chk("bp_rvalid", s_axi_rvalid, 1);
         tick();
      end
      s_axi_rready = 1;
      tick();
      s_axi_rready = 0;
   endtask

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 7) == 0)
         return ($urandom_range(0, 1) == 1) ? 32'h0001_0000 : 32'hFFFF_FFFC;
      return 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
   endfunction

   logic [31:0] d;
   logic [1:0]  rsp;
   int          lat;

   initial begin
      rstn = 0;
      s_axi_awaddr = 0; s_axi_awvalid = 0;
      s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0;
      s_axi_bready = 0;
      s_axi_araddr = 0; s_axi_arvalid = 0;
      s_axi_rready = 0;
      repeat (3) tick();
      chk("rst_awready", s_axi_awready, 0);
      chk("rst_wready", s_axi_wready, 0);
      chk("rst_arready", s_axi_arready, 0);
      chk("rst_bvalid", s_axi_bvalid, 0);
      chk("rst_bresp", s_axi_bresp, 0);
      chk("rst_rvalid", s_axi_rvalid, 0);
      chk("rst_rresp", s_axi_rresp, 0);
      chk("rst_rdata", s_axi_rdata, 0);
      rstn = 1;
      tick();
      chk("rel_awready", s_axi_awready, 1);
      chk("rel_wready", s_axi_wready, 1);
      chk("rel_arready", s_axi_arready, 1);

      wr(32'h10, 32'hDEAD_BEEF, 4'hF, 2, 0, rsp, lat);
      chk("wr10_bresp", rsp, 2'b00);
      chk("wr10_lat", lat, 1);
      rd(32'h10, 0, d, rsp, lat);
      chk("rd10_data", d, 32'hDEAD_BEEF);
      chk("rd10_resp", rsp, 2'b00);
      chk("rd10_lat", lat, 2);

      wr(32'h10, 32'h1122_3344, 4'b0101, 0, 0, rsp, lat);
      chk("part_bresp", rsp, 2'b00);
      rd(32'h10, 0, d, rsp, lat);
      chk("part_data", d, 32'hDE22_BE44);

      wr(32'h0, 32'h0123_4567, 4'hF, 1, 0, rsp, lat);
      wr(32'h0001_0000, 32'hFFFF_FFFF, 4'hF, 0, 0, rsp, lat);
      chk("oor_bresp", rsp, 2'b11);
      rd(32'h0001_0000, 0, d, rsp, lat);
      chk("oor_rdata", d, 32'h0);
      chk("oor_rresp", rsp, 2'b11);
      rd(32'h0, 0, d, rsp, lat);
      chk("oor_nochange", d, 32'h0123_4567);

      wr(32'h14, 32'h5555_AAAA, 4'b0000, 0, 0, rsp, lat);
      chk("strb0_bresp", rsp, 2'b00);
      rd(32'h10, 5, d, rsp, lat);
      chk("bp_rd_data", d, 32'hDE22_BE44);
      wr(32'h30, 32'hCAFE_F00D, 4'hF, 0, 5, rsp, lat);
      chk("bp_wr_bresp", rsp, 2'b00);

      wr(32'h20, 32'h0, 4'hF, 0, 0, rsp, lat);
      s_axi_awaddr = 32'h20; s_axi_awvalid = 1;
      s_axi_wdata = 32'hA5A5_A5A5; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
      s_axi_araddr = 32'h20; s_axi_arvalid = 1;
      s_axi_bready = 1; s_axi_rready = 1;
      tick();
      chk("same_edge", {29'd0, hs_aw, hs_w, hs_ar}, 32'h7);
      s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
      lat = 0;
      do begin tick(); lat++; end while (!s_axi_rvalid && lat < 20);
      chk("conc_old", s_axi_rdata, 32'h0);
      repeat (3) tick();
      s_axi_bready = 0; s_axi_rready = 0;
      rd(32'h20, 0, d, rsp, lat);
      chk("conc_new", d, 32'hA5A5_A5A5);

      for (int c = 0; c < 3000; c++) begin
         tick();
         if (!s_axi_awvalid || hs_aw) begin
            s_axi_awvalid = ($urandom_range(0, 2) == 0);
            s_axi_awaddr = rand_addr();
         end
         if (!s_axi_wvalid || hs_w) begin
            s_axi_wvalid = ($urandom_range(0, 2) == 0);
            s_axi_wdata = $urandom;
            s_axi_wstrb = 4'($urandom_range(0, 15));
         end
         if (!s_axi_arvalid || hs_ar) begin
            s_axi_arvalid = ($urandom_range(0, 1) == 0);
            s_axi_araddr = rand_addr();
         end
         s_axi_bready = ($urandom_range(0, 3) != 0);
         s_axi_rready = ($urandom_range(0, 3) != 0);
      end
      s_axi_bready = 1;
      s_axi_rready = 1;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (hs_aw) s_axi_awvalid = 0;
         if (hs_w) s_axi_wvalid = 0;
         if (hs_ar) s_axi_arvalid = 0;
      end
      repeat (4) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
